div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: div_start  input  1  decoded M-extension divide/remainder issue (sampled in IDLE only).
REQ-004 SHALL have ports: div_op  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have ports: rs1_val, rs2_val  input  32 each  dividend, divisor.
REQ-006 SHALL have ports: rd_in  input  5  destination register.
REQ-007 SHALL have ports: flush  input  1  kill in-flight operation.
REQ-008 SHALL have ports: core_start  output  1  one-cycle start pulse to unsigned iterative divider core.
REQ-009 SHALL have ports: core_dividend, core_divisor  output  32 each  unsigned magnitudes, stable from core_start until core_done.
REQ-010 SHALL have ports: core_abort  output  1  one-cycle pulse on flush while core is running.
REQ-011 SHALL have ports: core_done  input  1; core_quotient, core_remainder  input  32 each.
REQ-012 SHALL have ports: stall  output  1; busy  output  1; wb_valid  output  1; wb_rd  output  5; wb_data  output  32.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT, FINISH.
REQ-014 IDLE: div_start=1 with divisor nonzero and not signed overflow -> latch op, rd, operands, sign flags; go START.
REQ-015 START: assert core_start for exactly one cycle; go WAIT.
REQ-016 WAIT: hold until core_done=1; latch quotient/remainder; go FINISH.
REQ-017 FINISH: wb_valid=1 for one cycle with corrected result; return IDLE.
REQ-018 Signed ops (DIV, REM): core operands SHALL be two's-complement magnitudes; quotient negated when operand signs differ; remainder takes dividend sign.
REQ-019 Divisor zero: quotient 0xFFFFFFFF, remainder = rs1_val; core SHALL NOT be started; IDLE -> FINISH directly.
REQ-020 DIV/REM with rs1_val=0x80000000, rs2_val=0xFFFFFFFF: quotient 0x80000000, remainder 0; core not started; IDLE -> FINISH.
REQ-021 Selected result: DIV/DIVU -> quotient, REM/REMU -> remainder, registered into wb_data.
REQ-022 stall SHALL be combinationally high when div_start=1 in IDLE and in START/WAIT; low in FINISH and otherwise.
REQ-023 busy SHALL be high in START, WAIT, FINISH.
REQ-024 Latency: normal op = core latency + 3 cycles from div_start to wb_valid; special cases = 1 cycle.
REQ-025 flush in START/WAIT SHALL return to IDLE next cycle, pulse core_abort, suppress wb_valid; flush in FINISH SHALL suppress wb_valid; flush in IDLE overrides div_start.
REQ-026 core_done outside WAIT SHALL be ignored; div_start outside IDLE SHALL be ignored.
REQ-027 wb_rd, wb_data SHALL hold last values when wb_valid=0.

Reset
REQ-028 rst=1 SHALL force IDLE immediately; stall, busy, wb_valid, core_start, core_abort = 0; wb_rd = 0; wb_data = 0; core_dividend/core_divisor = 0.
REQ-029 Reset mid-operation SHALL discard the operation with no wb_valid and no core_abort pulse.

Structure
REQ-030 div_op encodings and FSM state encoding SHALL live in the shared CPU package.
REQ-031 Divider core SHALL be external; one sub-module div_sign_fix (operand magnitude and result sign correction, combinational) SHALL be instantiated.

Verification
REQ-032 DIVU 100/7 with 32-cycle core -> core_start one cycle after issue, wb_valid with wb_data=14, stall low in wb cycle.
REQ-033 DIV -7/2 -> wb_data=0xFFFFFFFD; REM -7/2 -> wb_data=0xFFFFFFFF; REMU 7/2 -> 1.
REQ-034 DIV 5/0 -> wb_data=0xFFFFFFFF, REM 5/0 -> 5, wb_valid next cycle, core_start never asserted.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; no core_start.
REQ-036 flush 5 cycles into WAIT -> core_abort one pulse, IDLE next cycle, no wb_valid; late core_done ignored.
REQ-037 rst asserted mid-WAIT -> all outputs 0 asynchronously; next div_start processed normally.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared CPU definitions for the M-extension divide controller:
// divide/remainder opcodes, controller FSM encoding and opcode decode helpers.
package div_ctrl_pkg;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake between the divide controller and the external unsigned
// iterative divider core.
interface div_ctrl_if;

    logic        core_start;
    logic        core_abort;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic        core_done;
    logic [31:0] core_quotient;
    logic [31:0] core_remainder;

    modport master (
        output core_start, core_abort, core_dividend, core_divisor,
        input  core_done, core_quotient, core_remainder
    );

    modport slave (
        input  core_start, core_abort, core_dividend, core_divisor,
        output core_done, core_quotient, core_remainder
    );

endinterface

// File: rtl/div_sign_fix.sv
// Sign handling around an unsigned divider: operand magnitudes and sign flags
// on issue, and sign correction plus quotient/remainder selection on completion.
module div_sign_fix (
    input  logic        is_signed,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] dividend_mag,
    output logic [31:0] divisor_mag,
    output logic        neg_quot,
    output logic        neg_rem,

    input  logic        neg_quot_q,
    input  logic        neg_rem_q,
    input  logic        sel_rem,
    input  logic [31:0] quotient,
    input  logic [31:0] remainder,
    output logic [31:0] result
);

    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign dividend_mag = (is_signed && rs1_val[31]) ? -rs1_val : rs1_val;
    assign divisor_mag  = (is_signed && rs2_val[31]) ? -rs2_val : rs2_val;

    // Quotient is negative when the signs differ; remainder follows the dividend.
    assign neg_quot = is_signed && (rs1_val[31] ^ rs2_val[31]);
    assign neg_rem  = is_signed && rs1_val[31];

    assign quot_fix = neg_quot_q ? -quotient  : quotient;
    assign rem_fix  = neg_rem_q  ? -remainder : remainder;
    assign result   = sel_rem ? rem_fix : quot_fix;

endmodule

// File: rtl/div_ctrl.sv
// Divide/remainder issue controller: sequences an external unsigned divider,
// short-circuits divide-by-zero and signed overflow, and writes back the result.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic [2:0]  div_op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    div_ctrl_if.master  core,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;

    logic        is_signed_in;
    logic        div_by_zero;
    logic        sign_ovf;
    logic        special;
    logic        issue;
    logic        done_ok;
    logic [31:0] special_result;
    logic [31:0] fixed_result;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic        neg_quot_in;
    logic        neg_rem_in;

    assign is_signed_in = op_is_signed(div_op);
    assign div_by_zero  = (rs2_val == 32'd0);
    assign sign_ovf     = is_signed_in && (rs1_val == INT_MIN) && (rs2_val == 32'hFFFF_FFFF);
    assign special      = div_by_zero || sign_ovf;

    // Flush in IDLE overrides div_start; flush in WAIT wins over core_done.
    assign issue   = (state == ST_IDLE) && div_start && !flush;
    assign done_ok = (state == ST_WAIT) && core.core_done && !flush;

    always_comb begin
        special_result = INT_MIN;
        if (div_by_zero)
            special_result = op_is_rem(div_op) ? rs1_val : 32'hFFFF_FFFF;
        else if (op_is_rem(div_op))
            special_result = 32'd0;
    end

    div_sign_fix u_sign_fix (
        .is_signed    (is_signed_in),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .dividend_mag (dividend_mag),
        .divisor_mag  (divisor_mag),
        .neg_quot     (neg_quot_in),
        .neg_rem      (neg_rem_in),
        .neg_quot_q   (neg_quot_q),
        .neg_rem_q    (neg_rem_q),
        .sel_rem      (op_is_rem(op_q)),
        .quotient     (core.core_quotient),
        .remainder    (core.core_remainder),
        .result       (fixed_result)
    );

    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:   if (issue) state_nxt = special ? ST_FINISH : ST_START;
            ST_START:  state_nxt = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT:   if (flush) state_nxt = ST_IDLE;
                       else if (core.core_done) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: operand and writeback registers are reset as well, since they drive outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 3'd0;
            rd_q       <= 5'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
        end else if (issue && !special) begin
            op_q       <= div_op;
            rd_q       <= rd_in;
            neg_quot_q <= neg_quot_in;
            neg_rem_q  <= neg_rem_in;
            dividend_q <= dividend_mag;
            divisor_q  <= divisor_mag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd   <= 5'd0;
            wb_data <= 32'd0;
        end else if (issue && special) begin
            wb_rd   <= rd_in;
            wb_data <= special_result;
        end else if (done_ok) begin
            wb_rd   <= rd_q;
            wb_data <= fixed_result;
        end
    end

    assign stall    = ((state == ST_IDLE) && div_start) || (state == ST_START) || (state == ST_WAIT);
    assign busy     = (state != ST_IDLE);
    assign wb_valid = (state == ST_FINISH) && !flush;

    assign core.core_start    = (state == ST_START) && !flush;
    assign core.core_abort    = flush && ((state == ST_START) || (state == ST_WAIT));
    assign core.core_dividend = dividend_q;
    assign core.core_divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural unsigned divider core whose
// done pulse arrives core_lat+1 cycles after the core_start cycle.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    div_ctrl_if core_if();

    div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .div_start (div_start),
        .div_op    (div_op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .flush     (flush),
        .core      (core_if),
        .stall     (stall),
        .busy      (busy),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    // Behavioural divider core
    int          core_lat;
    int          core_cnt;
    logic        core_run;
    logic        model_done;
    logic        extra_done;
    logic [31:0] model_q;
    logic [31:0] model_r;

    assign core_if.core_done      = model_done | extra_done;
    assign core_if.core_quotient  = model_q;
    assign core_if.core_remainder = model_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_run   <= 1'b0;
            core_cnt   <= 0;
            model_done <= 1'b0;
            model_q    <= 32'd0;
            model_r    <= 32'd0;
        end else begin
            model_done <= 1'b0;
            if (core_if.core_abort) begin
                core_run <= 1'b0;
            end else if (core_if.core_start) begin
                core_run <= 1'b1;
                core_cnt <= core_lat;
                if (core_if.core_divisor != 32'd0) begin
                    model_q <= core_if.core_dividend / core_if.core_divisor;
                    model_r <= core_if.core_dividend % core_if.core_divisor;
                end
            end else if (core_run) begin
                if (core_cnt == 1) begin
                    model_done <= 1'b1;
                    core_run   <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    int n_start = 0;
    int n_abort = 0;
    int n_wbv   = 0;

    always @(posedge clk) begin
        if (core_if.core_start) n_start <= n_start + 1;
        if (core_if.core_abort) n_abort <= n_abort + 1;
        if (wb_valid)           n_wbv   <= n_wbv + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for wb_valid; lat counts cycles from issue.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output logic [31:0] data,
                         output logic [4:0] rdo, output int starts, output logic stall_issue,
                         output logic stall_wb, output logic start_c1);
        int base;
        @(negedge clk);
        base      = n_start;
        div_start = 1'b1;
        div_op    = op;
        rs1_val   = a;
        rs2_val   = b;
        rd_in     = rd;
        #1 stall_issue = stall;
        @(negedge clk);
        div_start = 1'b0;
        rs1_val   = 32'hDEAD_BEEF;
        rs2_val   = 32'h0000_0003;
        rd_in     = 5'h1F;
        lat       = 1;
        #1 start_c1 = core_if.core_start;
        while (!wb_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        #1;
        data     = wb_data;
        rdo      = wb_rd;
        stall_wb = stall;
        starts   = n_start - base;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        logic        special;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        int          lat;
        int          starts;
        int          ab_base;
        int          wb_base;
        int          st_base;
        logic [31:0] data;
        logic [4:0]  rdo;
        logic        s_issue;
        logic        s_wb;
        logic        s_c1;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         32, 1'b0};
        vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  4,  1'b0};
        vecs[2]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  4,  1'b0};
        vecs[3]  = '{OP_REMU, 32'd7,          32'd2,          5'd8,  32'd1,          4,  1'b0};
        vecs[4]  = '{OP_DIV,  32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  4,  1'b1};
        vecs[5]  = '{OP_REM,  32'd5,          32'd0,          5'd10, 32'd5,          4,  1'b1};
        vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  4,  1'b1};
        vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          4,  1'b1};
        vecs[8]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          3,  1'b0};
        vecs[9]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd14, 32'hFFFF_FFFD,  5,  1'b0};
        vecs[10] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          5,  1'b0};
        vecs[11] = '{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  5'd16, 32'd4,          6,  1'b0};
        vecs[12] = '{OP_REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  5'd17, 32'hFFFF_FFFE,  6,  1'b0};
        vecs[13] = '{OP_DIVU, 32'd5,          32'd0,          5'd18, 32'hFFFF_FFFF,  4,  1'b1};
        vecs[14] = '{OP_REMU, 32'd5,          32'd0,          5'd19, 32'd5,          4,  1'b1};
        vecs[15] = '{OP_REMU, 32'hFFFF_FFFF,  32'h0000_0010,  5'd20, 32'd15,         2,  1'b0};

        rst        = 1'b1;
        div_start  = 1'b0;
        div_op     = OP_DIV;
        rs1_val    = 32'd0;
        rs2_val    = 32'd0;
        rd_in      = 5'd0;
        flush      = 1'b0;
        core_lat   = 32;
        extra_done = 1'b0;

        #1;
        check("reset stall",     {31'd0, stall},              32'd0);
        check("reset busy",      {31'd0, busy},               32'd0);
        check("reset wb_valid",  {31'd0, wb_valid},           32'd0);
        check("reset core_start",{31'd0, core_if.core_start}, 32'd0);
        check("reset wb_data",   wb_data,                     32'd0);
        check("reset wb_rd",     {27'd0, wb_rd},              32'd0);
        check("reset dividend",  core_if.core_dividend,       32'd0);
        check("reset divisor",   core_if.core_divisor,        32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            core_lat = vecs[i].lat;
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, data, rdo, starts, s_issue, s_wb, s_c1);
            check($sformatf("v%0d wb_data", i), data, vecs[i].exp);
            check($sformatf("v%0d wb_rd", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d latency", i), lat, vecs[i].special ? 1 : vecs[i].lat + 3);
            check($sformatf("v%0d core_starts", i), starts, vecs[i].special ? 0 : 1);
            check($sformatf("v%0d start_cycle1", i), {31'd0, s_c1}, {31'd0, !vecs[i].special});
            check($sformatf("v%0d stall_issue", i), {31'd0, s_issue}, 32'd1);
            check($sformatf("v%0d stall_wb", i), {31'd0, s_wb}, 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("v%0d wb_valid_1cyc", i), {31'd0, wb_valid}, 32'd0);
            check($sformatf("v%0d wb_data_hold", i), wb_data, vecs[i].exp);
        end

        // Flush five cycles into WAIT, then a stray core_done in IDLE
        core_lat = 32;
        @(negedge clk);
        ab_base = n_abort; wb_base = n_wbv; st_base = n_start;
        div_start = 1'b1; div_op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3;
        @(negedge clk);
        div_start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush core_abort", {31'd0, core_if.core_abort}, 32'd1);
        check("flush wb_valid",   {31'd0, wb_valid},           32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush idle busy",   {31'd0, busy},  32'd0);
        check("flush idle stall",  {31'd0, stall}, 32'd0);
        check("flush abort count", n_abort - ab_base, 32'd1);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        #1;
        check("late done busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush no wb_valid",   n_wbv - wb_base,   32'd0);
        check("flush start count",   n_start - st_base, 32'd1);

        // Flush in IDLE overrides div_start
        @(negedge clk);
        wb_base = n_wbv; st_base = n_start;
        div_start = 1'b1; flush = 1'b1; div_op = OP_DIV; rs1_val = 32'd100; rs2_val = 32'd7;
        @(negedge clk);
        div_start = 1'b0; flush = 1'b0;
        #1;
        check("idle flush busy",   {31'd0, busy},     32'd0);
        check("idle flush starts", n_start - st_base, 32'd0);

        // Flush in FINISH suppresses wb_valid
        @(negedge clk);
        div_start = 1'b1; div_op = OP_DIV; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd4;
        @(negedge clk);
        div_start = 1'b0; flush = 1'b1;
        #1;
        check("finish flush wb_valid", {31'd0, wb_valid}, 32'd0);
        check("finish flush busy",     {31'd0, busy},     32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("finish flush idle", {31'd0, busy},   32'd0);
        check("flush no wb",       n_wbv - wb_base, 32'd0);

        // div_start held high while busy must be ignored
        core_lat = 4;
        @(negedge clk);
        div_start = 1'b1; div_op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd7;
        @(negedge clk);
        div_op = OP_DIV; rs1_val = 32'd9; rs2_val = 32'd0; rd_in = 5'd8;
        lat = 1;
        while (!wb_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        div_start = 1'b0;
        #1;
        check("busy issue wb_data", wb_data,        32'd14);
        check("busy issue wb_rd",   {27'd0, wb_rd}, 32'd7);
        check("busy issue latency", lat,            32'd7);
        @(negedge clk);
        #1;
        check("busy issue idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-WAIT
        core_lat = 32;
        @(negedge clk);
        ab_base = n_abort; wb_base = n_wbv;
        div_start = 1'b1; div_op = OP_DIV; rs1_val = 32'hFFFF_FFF9; rs2_val = 32'd2; rd_in = 5'd9;
        @(negedge clk);
        div_start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst stall",      {31'd0, stall},              32'd0);
        check("rst busy",       {31'd0, busy},               32'd0);
        check("rst wb_valid",   {31'd0, wb_valid},           32'd0);
        check("rst core_start", {31'd0, core_if.core_start}, 32'd0);
        check("rst core_abort", {31'd0, core_if.core_abort}, 32'd0);
        check("rst wb_rd",      {27'd0, wb_rd},              32'd0);
        check("rst wb_data",    wb_data,                     32'd0);
        check("rst dividend",   core_if.core_dividend,       32'd0);
        check("rst divisor",    core_if.core_divisor,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst no abort", n_abort - ab_base, 32'd0);
        check("rst no wb",    n_wbv - wb_base,   32'd0);
        core_lat = 8;
        do_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd21, lat, data, rdo, starts, s_issue, s_wb, s_c1);
        check("post rst wb_data", data,          32'hFFFF_FFF2);
        check("post rst wb_rd",   {27'd0, rdo},  32'd21);
        check("post rst latency", lat,           32'd11);
        check("post rst starts",  starts,        32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
